// File: rtl/grayblast_pkg.sv
// Shared constants for the grayscale pixel path: collector, VGA output
// stage and top-level parameter overrides all pull their sizes from here.
package grayblast_pkg;

  localparam int GB_PIXEL_BITS = 2;
  localparam int GB_FIFO_DEPTH = 8;
  localparam int GB_PTR_W      = $clog2(GB_FIFO_DEPTH);
  localparam int GB_LEVEL_W    = GB_PTR_W + 1;

  // Width of a counter that must hold 0..pb-1; never narrower than 1 bit.
  function automatic int cnt_width(input int pb);
    return (pb > 1) ? $clog2(pb) : 1;
  endfunction

endpackage

// File: rtl/pixel_bit_collector_if.sv
// Pixel handshake between the bit collector (master) and the VGA stage.
// Handshake: the master holds pixel_valid high with pixel_data stable while
// a word is available; a word is transferred on every rising clock edge
// where pixel_valid and pixel_ready are both 1. pixel_ready may be raised
// with pixel_valid low; that transfers nothing.
interface pixel_bit_collector_if
  import grayblast_pkg::*;
#(
  parameter int PIXEL_BITS = GB_PIXEL_BITS
);

  logic                  pixel_valid;
  logic                  pixel_ready;
  logic [PIXEL_BITS-1:0] pixel_data;

  modport master (
    output pixel_valid,
    output pixel_data,
    input  pixel_ready
  );

  modport slave (
    input  pixel_valid,
    input  pixel_data,
    output pixel_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. Pointers carry an extra wrap
// bit so full and empty are distinguished without a separate counter.
// A push while full is accepted only when a pop frees a slot that cycle.
module sync_fifo
  import grayblast_pkg::*;
#(
  parameter int WIDTH = GB_PIXEL_BITS,
  parameter int DEPTH = GB_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE = {{PW{1'b0}}, 1'b1};

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Status flags, accepted operations and the fall-through head word.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    rd_data = empty ? '0 : mem[rd_ptr[PW-1:0]];
  end

  // Pointer and level registers; clear has priority over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pixel_bit_collector.sv
// Packs the core array's serial bit stream MSB-first into pixel words,
// buffers them in a FWFT FIFO and offers them to the VGA stage. Sticky
// overflow/underflow flags report dropped words and premature requests.
module pixel_bit_collector
  import grayblast_pkg::*;
#(
  parameter int PIXEL_BITS = GB_PIXEL_BITS,
  parameter int FIFO_DEPTH = GB_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_bit,
  input  logic                          output_bit,
  input  logic                          frame_start,
  pixel_bit_collector_if.master         pix,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int CW = cnt_width(PIXEL_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(PIXEL_BITS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0]         bit_cnt;
  logic [PIXEL_BITS-1:0] shift_reg;
  logic [PIXEL_BITS:0]   shift_ext;
  logic [PIXEL_BITS-1:0] word;
  logic                  word_done;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [PIXEL_BITS-1:0] head_data;

  // Next shift contents; the widened vector keeps PIXEL_BITS=1 legal.
  always_comb begin
    shift_ext = {shift_reg, output_bit};
    word      = shift_ext[PIXEL_BITS-1:0];
    word_done = valid_bit & ~frame_start & (bit_cnt == LAST_BIT);
    pop       = ~fifo_empty & pix.pixel_ready & ~frame_start;
  end

  // Serial-to-parallel packer; frame_start discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (frame_start) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (valid_bit) begin
      shift_reg <= word;
      bit_cnt   <= word_done ? '0 : bit_cnt + CNT_ONE;
    end
  end

  // Sticky debug flags, cleared only by reset or a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (frame_start) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (word_done && fifo_full && !pop) overflow  <= 1'b1;
      if (pix.pixel_ready && fifo_empty)  underflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (PIXEL_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (frame_start),
    .push      (word_done),
    .push_data (word),
    .pop       (pop),
    .rd_data   (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  // Present the FIFO head directly to the VGA stage.
  always_comb begin
    pix.pixel_valid = ~fifo_empty;
    pix.pixel_data  = head_data;
  end

endmodule
